// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller holding SR, Cause and EPC for a 5-stage MIPS core.
// Optional define CP0_EPC_BYPASS_EN forwards an in-flight mtc0 to EPC onto EPCOut.
module cp0_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ExcCode_M,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  CP0Addr,
  input  logic        CP0WrEn,
  input  logic [31:0] CP0DataIn,
  input  logic        EXLClr,
  output logic [31:0] CP0DataOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0]  EXC_NONE = 5'b11111;
  localparam logic [4:0]  IDX_SR   = 5'd12;
  localparam logic [4:0]  IDX_CAUSE = 5'd13;
  localparam logic [4:0]  IDX_EPC  = 5'd14;
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [4:0]  exc_code;
  logic [31:0] epc_base;
  logic        wr_sr;
  logic        wr_epc;

  // Gating with reset_n keeps Req low while the core is held in reset.
  always_comb begin
    int_req  = reset_n & sr_q[0] & ~sr_q[1] & (|(HWInt & sr_q[15:10]));
    exc_req  = reset_n & (ExcCode_M != EXC_NONE) & ~sr_q[1];
    req      = int_req | exc_req;
    exc_code = int_req ? 5'd0 : ExcCode_M;
    epc_base = BD_M ? (PC_M - 32'd4) : PC_M;
    wr_sr    = CP0WrEn & (CP0Addr == IDX_SR)  & ~req;
    wr_epc   = CP0WrEn & (CP0Addr == IDX_EPC) & ~req;
  end

  assign Req = req;

  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cause_d[15:10] = HWInt;
    if (req) begin
      cause_d[6:2] = exc_code;
      cause_d[31]  = BD_M;
      epc_d        = epc_base & 32'hFFFF_FFFC;
      sr_d[1]      = 1'b1;
    end else begin
      if (wr_sr) begin
        sr_d = CP0DataIn & SR_WMASK;
      end
      if (wr_epc) begin
        epc_d = {CP0DataIn[31:2], 2'b00};
      end
      // eret clears EXL after any same-cycle mtc0 to SR has been applied.
      if (EXLClr) begin
        sr_d[1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q    <= 32'h0;
      cause_q <= 32'h0;
      epc_q   <= 32'h0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    case (CP0Addr)
      IDX_SR:    CP0DataOut = sr_q;
      IDX_CAUSE: CP0DataOut = cause_q;
      IDX_EPC:   CP0DataOut = epc_q;
      default:   CP0DataOut = 32'h0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign EPCOut = wr_epc ? {CP0DataIn[31:2], 2'b00} : epc_q;
`else
  assign EPCOut = epc_q;
`endif

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: field-level CP0 model checked every cycle plus literal pins.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  ExcCode_M;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [5:0]  HWInt;
  logic [4:0]  CP0Addr;
  logic        CP0WrEn;
  logic [31:0] CP0DataIn;
  logic        EXLClr;
  logic [31:0] CP0DataOut;
  logic [31:0] EPCOut;
  logic        Req;

  cp0_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ExcCode_M(ExcCode_M), .PC_M(PC_M), .BD_M(BD_M),
    .HWInt(HWInt), .CP0Addr(CP0Addr), .CP0WrEn(CP0WrEn), .CP0DataIn(CP0DataIn),
    .EXLClr(EXLClr), .CP0DataOut(CP0DataOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model kept as named architectural fields rather than packed registers.
  logic       m_ie, m_exl, m_bd;
  logic [5:0] m_im, m_ip;
  logic [4:0] m_code;
  int unsigned m_epc_word;

  logic       n_ie, n_exl, n_bd;
  logic [5:0] n_im, n_ip;
  logic [4:0] n_code;
  int unsigned n_epc_word;

  logic        e_int, e_exc, e_req;
  logic [31:0] e_sr, e_cause, e_epc, e_out, e_epcout;

  logic        lit_en = 1'b0;
  int          lit_sel = 0;
  logic [31:0] lit_val = 32'h0;
  string       lit_name = "";

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    e_sr    = {16'h0, m_im, 8'h0, m_exl, m_ie};
    e_cause = {m_bd, 15'h0, m_ip, 3'h0, m_code, 2'b00};
    e_epc   = m_epc_word << 2;
    e_int   = (reset_n === 1'b1) && m_ie && !m_exl && ((HWInt & m_im) != 6'd0);
    e_exc   = (reset_n === 1'b1) && (ExcCode_M != 5'd31) && !m_exl;
    e_req   = e_int || e_exc;
    if (CP0Addr == 5'd12)      e_out = e_sr;
    else if (CP0Addr == 5'd13) e_out = e_cause;
    else if (CP0Addr == 5'd14) e_out = e_epc;
    else                       e_out = 32'h0;
    e_epcout = e_epc;
`ifdef CP0_EPC_BYPASS_EN
    if (CP0WrEn && CP0Addr == 5'd14 && !e_req) e_epcout = {CP0DataIn[31:2], 2'b00};
`endif
    check("model_req", {31'h0, Req}, {31'h0, e_req});
    check("model_dout", CP0DataOut, e_out);
    check("model_epcout", EPCOut, e_epcout);
    if (lit_en) begin
      case (lit_sel)
        0:       check(lit_name, {31'h0, Req}, lit_val);
        1:       check(lit_name, CP0DataOut, lit_val);
        default: check(lit_name, EPCOut, lit_val);
      endcase
    end
    $display("cyc t=%0t rst_n=%b exc=%0d pc=%h hw=%b addr=%0d wr=%b din=%h eclr=%b -> req=%b dout=%h epc=%h",
             $time, reset_n, ExcCode_M, PC_M, HWInt, CP0Addr, CP0WrEn, CP0DataIn, EXLClr,
             Req, CP0DataOut, EPCOut);

    n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_im = m_im; n_code = m_code;
    n_epc_word = m_epc_word;
    n_ip = HWInt;
    if (e_req) begin
      n_code     = e_int ? 5'd0 : ExcCode_M;
      n_bd       = BD_M;
      n_epc_word = (BD_M ? PC_M - 4 : PC_M) >> 2;
      n_exl      = 1'b1;
    end else begin
      if (CP0WrEn && CP0Addr == 5'd12) begin
        n_ie  = CP0DataIn[0];
        n_exl = CP0DataIn[1];
        n_im  = CP0DataIn[15:10];
      end
      if (CP0WrEn && CP0Addr == 5'd14) n_epc_word = CP0DataIn >> 2;
      if (EXLClr) n_exl = 1'b0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ie <= 1'b0; m_exl <= 1'b0; m_bd <= 1'b0; m_im <= 6'd0; m_ip <= 6'd0;
      m_code <= 5'd0; m_epc_word <= 0;
    end else begin
      m_ie <= n_ie; m_exl <= n_exl; m_bd <= n_bd; m_im <= n_im; m_ip <= n_ip;
      m_code <= n_code; m_epc_word <= n_epc_word;
    end
  end

  task automatic idle();
    ExcCode_M = 5'd31; PC_M = 32'h0; BD_M = 1'b0; HWInt = 6'd0;
    CP0Addr = 5'd0; CP0WrEn = 1'b0; CP0DataIn = 32'h0; EXLClr = 1'b0;
  endtask

  task automatic lit(input int sel, input logic [31:0] val, input string nm);
    lit_en = 1'b1; lit_sel = sel; lit_val = val; lit_name = nm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    ExcCode_M = 5'd12;
    lit(0, 32'h0, "req_in_reset");
    tick();
    lit(2, 32'h0, "epcout_in_reset");
    tick();
    idle();
    tick();
    reset_n = 1'b1;

    // Overflow exception
    idle(); ExcCode_M = 5'd12; PC_M = 32'h3010;
    lit(0, 32'h1, "ov_req"); tick();
    idle(); CP0Addr = 5'd14; lit(1, 32'h3010, "ov_epc"); tick();
    idle(); CP0Addr = 5'd13; lit(1, 32'h30, "ov_cause"); tick();
    idle(); CP0Addr = 5'd12; lit(1, 32'h2, "ov_sr"); tick();

    // Nested exception blocked by EXL, then eret
    idle(); ExcCode_M = 5'd8; PC_M = 32'h3100; lit(0, 32'h0, "nested_req"); tick();
    idle(); CP0Addr = 5'd14; EXLClr = 1'b1; lit(1, 32'h3010, "nested_epc"); tick();
    idle(); CP0Addr = 5'd12; lit(1, 32'h0, "eret_sr"); tick();

    // Delay-slot exception
    idle(); ExcCode_M = 5'd4; PC_M = 32'h3024; BD_M = 1'b1; lit(0, 32'h1, "bd_req"); tick();
    idle(); CP0Addr = 5'd14; lit(1, 32'h3020, "bd_epc"); tick();
    idle(); CP0Addr = 5'd13; EXLClr = 1'b1; lit(1, 32'h8000_0010, "bd_cause"); tick();

    // Interrupt priority over RI
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd12; CP0DataIn = 32'h0000_0401; tick();
    idle(); CP0Addr = 5'd12; lit(1, 32'h401, "sr_write"); tick();
    idle(); HWInt = 6'b000001; ExcCode_M = 5'd10; lit(0, 32'h1, "int_req"); tick();
    idle(); CP0Addr = 5'd13; EXLClr = 1'b1; lit(1, 32'h400, "int_cause"); tick();

    // Interrupt masked by IE=0
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd12; CP0DataIn = 32'h0000_0400; tick();
    idle(); HWInt = 6'b000001; CP0Addr = 5'd12; lit(0, 32'h0, "masked_req"); tick();
    idle(); CP0Addr = 5'd13; tick();

    // mtc0 SR together with eret: EXL forced low afterwards
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd12; CP0DataIn = 32'h0000_0002; tick();
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd12; CP0DataIn = 32'h0000_0403; EXLClr = 1'b1; tick();
    idle(); CP0Addr = 5'd12; lit(1, 32'h401, "mtc0_eret_sr"); tick();

    // mtc0 EPC colliding with AdES
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd14; CP0DataIn = 32'h4000; ExcCode_M = 5'd5; PC_M = 32'h3008;
    lit(0, 32'h1, "collide_req"); tick();
    idle(); CP0Addr = 5'd14; EXLClr = 1'b1; lit(1, 32'h3008, "collide_epc"); tick();

    // Writes to Cause and unimplemented indices are ignored
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd13; CP0DataIn = 32'hFFFF_FFFF; tick();
    idle(); CP0Addr = 5'd13; lit(1, 32'h14, "cause_ro"); tick();
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd5; CP0DataIn = 32'hFF; lit(1, 32'h0, "idx5_read"); tick();

    // EPC bypass
    idle(); CP0WrEn = 1'b1; CP0Addr = 5'd14; CP0DataIn = 32'h4003;
`ifdef CP0_EPC_BYPASS_EN
    lit(2, 32'h4000, "bypass_epcout");
`else
    lit(2, 32'h3008, "nobypass_epcout");
`endif
    tick();
    idle(); CP0Addr = 5'd14; lit(2, 32'h4000, "epcout_after_wr"); tick();

    // Mid-test reset
    idle(); HWInt = 6'h3F; ExcCode_M = 5'd12; CP0Addr = 5'd12;
    reset_n = 1'b0;
    lit(1, 32'h0, "rst_sr"); tick();
    idle(); HWInt = 6'h3F; ExcCode_M = 5'd12; CP0Addr = 5'd13; lit(1, 32'h0, "rst_cause"); tick();
    idle(); CP0Addr = 5'd14; lit(1, 32'h0, "rst_epc"); tick();
    reset_n = 1'b1;
    idle(); HWInt = 6'h2A; CP0Addr = 5'd13; tick();
    idle(); CP0Addr = 5'd13; lit(1, 32'h0000_A800, "post_rst_ip"); tick();
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
